// File: rtl/mx_rx_frame_buf.sv
// mx_rx_frame_buf: circular byte buffer for mx_rcvr frames; a frame is readable only after it ends cleanly.
// Ports: clk, reset (sync, active-high); cardet/write/data/error from mx_rcvr;
//        rrdy/rdata/rrd first-word-fall-through read port; frame_ok/frame_drop one-cycle pulses;
//        used = committed bytes not yet read.
// Optional: define MX_RX_STATS_EN to add saturating ok_cnt/drop_cnt frame counters.
module mx_rx_frame_buf #(
  parameter int DEPTH = 256,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cardet,
  input  logic          write,
  input  logic [7:0]    data,
  input  logic          error,
  output logic          rrdy,
  output logic [7:0]    rdata,
  input  logic          rrd,
  output logic          frame_ok,
  output logic          frame_drop,
`ifdef MX_RX_STATS_EN
  output logic [15:0]   ok_cnt,
  output logic [15:0]   drop_cnt,
`endif
  output logic [AW:0]   used
);
  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;
  state_t r_state, w_state_nxt;
  logic [AW:0] r_wr_ptr, r_commit_ptr, r_rd_ptr, w_wr_nxt, w_commit_nxt;
  logic [7:0] r_mem [DEPTH];
  logic r_frame_ok, r_frame_drop, w_ok, w_drop, w_store, w_full, w_pop;
  // speculative occupancy includes the unread committed bytes, so a full buffer blocks the frame
  assign w_full = (r_wr_ptr - r_rd_ptr) == (AW+1)'(DEPTH);
  assign rrdy = r_rd_ptr != r_commit_ptr;
  assign rdata = r_mem[r_rd_ptr[AW-1:0]];
  assign used = r_commit_ptr - r_rd_ptr;
  assign w_pop = rrd && rrdy;
  assign frame_ok = r_frame_ok;
  assign frame_drop = r_frame_drop;
  always_comb begin
    w_state_nxt = r_state;
    w_wr_nxt = r_wr_ptr;
    w_commit_nxt = r_commit_ptr;
    w_store = 1'b0;
    w_ok = 1'b0;
    w_drop = 1'b0;
    case (r_state)
      IDLE: if (cardet) begin
        w_state_nxt = RECV;
        w_wr_nxt = r_commit_ptr;
      end
      RECV: if (error || (write && w_full)) begin
        w_state_nxt = DROP;
        w_wr_nxt = r_commit_ptr;
        w_drop = 1'b1;
      end else begin
        w_store = write;
        w_wr_nxt = write ? r_wr_ptr + (AW+1)'(1) : r_wr_ptr;
        // a byte written in the closing cycle still belongs to the frame
        if (!cardet) begin
          w_state_nxt = IDLE;
          w_ok = w_wr_nxt != r_commit_ptr;
          w_commit_nxt = w_wr_nxt;
        end
      end
      DROP: w_state_nxt = cardet ? DROP : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_wr_ptr <= '0;
      r_commit_ptr <= '0;
      r_rd_ptr <= '0;
      r_frame_ok <= 1'b0;
      r_frame_drop <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wr_ptr <= w_wr_nxt;
      r_commit_ptr <= w_commit_nxt;
      r_rd_ptr <= w_pop ? r_rd_ptr + (AW+1)'(1) : r_rd_ptr;
      r_frame_ok <= w_ok;
      r_frame_drop <= w_drop;
    end
  end
  always_ff @(posedge clk) begin
    if (w_store) r_mem[r_wr_ptr[AW-1:0]] <= data;
  end
`ifdef MX_RX_STATS_EN
  logic [15:0] r_ok_cnt, r_drop_cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ok_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (r_frame_ok && r_ok_cnt != 16'hFFFF) r_ok_cnt <= r_ok_cnt + 16'd1;
      if (r_frame_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end
  assign ok_cnt = r_ok_cnt;
  assign drop_cnt = r_drop_cnt;
`endif
endmodule

// File: tb/tb_mx_rx_frame_buf.sv
// tb_mx_rx_frame_buf: checks a 256-byte and an 8-byte buffer against a queue-based frame model.
module tb_mx_rx_frame_buf;
  logic clk = 1'b0, reset = 1'b1, cardet = 1'b0, write = 1'b0, error = 1'b0, rrd = 1'b0;
  logic [7:0] data = 8'h00;
  logic rrdy_o [2];
  logic [7:0] rdata_o [2];
  logic ok_o [2], drop_o [2];
  logic [8:0] used_b;
  logic [3:0] used_s;
  int total = 0, bad = 0;
  int obs_ok [2] = '{0, 0};
  int obs_drop [2] = '{0, 0};
  int dep [2] = '{256, 8};
  logic [7:0] mq [2][$];
  logic [7:0] mf [2][$];
  int ms [2] = '{0, 0};
  logic eok [2], edrop [2];
  int base_ok, base_drop;
  always #5 clk = ~clk;
  mx_rx_frame_buf #(.DEPTH(256)) u_big (
    .clk(clk), .reset(reset), .cardet(cardet), .write(write), .data(data), .error(error),
    .rrdy(rrdy_o[0]), .rdata(rdata_o[0]), .rrd(rrd), .frame_ok(ok_o[0]), .frame_drop(drop_o[0]), .used(used_b));
  mx_rx_frame_buf #(.DEPTH(8)) u_small (
    .clk(clk), .reset(reset), .cardet(cardet), .write(write), .data(data), .error(error),
    .rrdy(rrdy_o[1]), .rdata(rdata_o[1]), .rrd(rrd), .frame_ok(ok_o[1]), .frame_drop(drop_o[1]), .used(used_s));
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // model: committed queue mq, in-flight frame mf, ms = 0 idle / 1 receiving / 2 discarding
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit pop;
      pop = rrd && mq[k].size() > 0;
      eok[k] = 1'b0;
      edrop[k] = 1'b0;
      if (reset) begin
        mq[k].delete();
        mf[k].delete();
        ms[k] = 0;
        continue;
      end
      if (ms[k] == 0) begin
        if (cardet) begin
          ms[k] = 1;
          mf[k].delete();
        end
      end else if (ms[k] == 1) begin
        if (error || (write && mq[k].size() + mf[k].size() == dep[k])) begin
          mf[k].delete();
          ms[k] = 2;
          edrop[k] = 1'b1;
        end else begin
          if (write) mf[k].push_back(data);
          if (!cardet) begin
            if (mf[k].size() > 0) begin
              eok[k] = 1'b1;
              for (int i = 0; i < mf[k].size(); i++) mq[k].push_back(mf[k][i]);
            end
            mf[k].delete();
            ms[k] = 0;
          end
        end
      end else if (!cardet) ms[k] = 0;
      if (pop) void'(mq[k].pop_front());
    end
  endtask
  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      logic [31:0] u;
      u = (k == 0) ? 32'(used_b) : 32'(used_s);
      obs_ok[k] += int'(ok_o[k]);
      obs_drop[k] += int'(drop_o[k]);
      chk($sformatf("rrdy%0d", k), 32'(rrdy_o[k]), 32'(mq[k].size() > 0));
      chk($sformatf("used%0d", k), u, 32'(mq[k].size()));
      chk($sformatf("frame_ok%0d", k), 32'(ok_o[k]), 32'(eok[k]));
      chk($sformatf("frame_drop%0d", k), 32'(drop_o[k]), 32'(edrop[k]));
      if (mq[k].size() > 0) chk($sformatf("rdata%0d", k), 32'(rdata_o[k]), 32'(mq[k][0]));
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask
  task automatic send_frame(int n, int fixed, int err_at, bit end_rrd);
    cardet = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      write = 1'b1;
      data = (fixed >= 0) ? 8'(fixed) : 8'($urandom);
      tick();
      write = 1'b0;
      if ($urandom_range(3) == 0) tick();
      if (i == err_at) begin
        error = 1'b1;
        tick();
        error = 1'b0;
      end
    end
    cardet = 1'b0;
    rrd = end_rrd;
    tick();
    rrd = 1'b0;
    tick();
  endtask
  task automatic drain();
    rrd = 1'b1;
    for (int i = 0; i < 700 && (mq[0].size() > 0 || mq[1].size() > 0); i++) tick();
    rrd = 1'b0;
    tick();
    chk("drain_rrdy_big", 32'(rrdy_o[0]), 32'd0);
    chk("drain_rrdy_small", 32'(rrdy_o[1]), 32'd0);
  endtask
  initial begin
    tick();
    tick();
    chk("reset_used", 32'(used_b), 32'd0);
    reset = 1'b0;
    tick();
    // single byte frame
    cardet = 1'b1;
    tick();
    write = 1'b1;
    data = 8'h55;
    tick();
    write = 1'b0;
    cardet = 1'b0;
    tick();
    chk("t1_ok", 32'(ok_o[0]), 32'd1);
    chk("t1_rdata", 32'(rdata_o[0]), 32'h55);
    chk("t1_used", 32'(used_b), 32'd1);
    rrd = 1'b1;
    tick();
    rrd = 1'b0;
    chk("t1_empty", 32'(rrdy_o[0]), 32'd0);
    chk("t1_used0", 32'(used_b), 32'd0);
    // 24 random bytes
    base_ok = obs_ok[0];
    base_drop = obs_drop[0];
    send_frame(24, -1, -1, 1'b0);
    chk("t2_used", 32'(used_b), 32'd24);
    drain();
    chk("t2_ok_once", 32'(obs_ok[0] - base_ok), 32'd1);
    chk("t2_no_drop", 32'(obs_drop[0] - base_drop), 32'd0);
    // error mid-frame, then a clean 0xF0 frame
    base_drop = obs_drop[0];
    send_frame(3, -1, 2, 1'b0);
    chk("t3_drop_once", 32'(obs_drop[0] - base_drop), 32'd1);
    chk("t3_rrdy", 32'(rrdy_o[0]), 32'd0);
    chk("t3_used", 32'(used_b), 32'd0);
    send_frame(1, 'hF0, -1, 1'b0);
    chk("t3_rdata", 32'(rdata_o[0]), 32'hF0);
    chk("t3_used1", 32'(used_b), 32'd1);
    drain();
    // carrier with no bytes
    base_ok = obs_ok[0];
    base_drop = obs_drop[0];
    cardet = 1'b1;
    tick();
    tick();
    cardet = 1'b0;
    tick();
    tick();
    chk("t4_no_ok", 32'(obs_ok[0] - base_ok), 32'd0);
    chk("t4_no_drop", 32'(obs_drop[0] - base_drop), 32'd0);
    chk("t4_used", 32'(used_b), 32'd0);
    // overflow on the 8-byte buffer, then an exactly-full frame
    base_drop = obs_drop[1];
    send_frame(9, -1, -1, 1'b0);
    chk("t5_drop_small", 32'(obs_drop[1] - base_drop), 32'd1);
    chk("t5_used_small", 32'(used_s), 32'd0);
    chk("t5_used_big", 32'(used_b), 32'd9);
    send_frame(8, -1, -1, 1'b0);
    chk("t5_full_small", 32'(used_s), 32'd8);
    chk("t5_used_big2", 32'(used_b), 32'd17);
    drain();
    // commit coinciding with a read
    send_frame(3, -1, -1, 1'b0);
    send_frame(2, -1, -1, 1'b1);
    chk("t6_used", 32'(used_b), 32'd4);
    drain();
    // reset in the middle of a frame
    send_frame(2, -1, -1, 1'b0);
    cardet = 1'b1;
    tick();
    write = 1'b1;
    data = 8'hA5;
    tick();
    reset = 1'b1;
    write = 1'b0;
    cardet = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("t7_used", 32'(used_b), 32'd0);
    chk("t7_rrdy", 32'(rrdy_o[0]), 32'd0);
    // random traffic
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(15) == 0) cardet = ~cardet;
      write = 1'($urandom_range(1));
      data = 8'($urandom);
      error = $urandom_range(63) == 0;
      rrd = $urandom_range(2) == 0;
      tick();
    end
    cardet = 1'b0;
    write = 1'b0;
    error = 1'b0;
    rrd = 1'b0;
    tick();
    tick();
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
